fp16_to_fixed_pipe: RTL and testbench

Pipelined converter from IEEE-754 binary16 to signed 16-bit two's-complement fixed point with `FRAC_BITS` fractional bits (default Q3.12). It is the inverse of the int/fixed-to-fp16 path used in the attention layer. At `FRAC_BITS=12`, fixed value `v` maps to fp16 exponent field `3+msb(|v|)`, and this block returns fp16 results to the same fixed-point domain. Three register stages, a valid/ready handshake on both sides, round-to-nearest-even, and saturation with an overflow flag.

---
 rtl/fp16_to_fixed_pipe.sv | 70 +++++++
 tb/tb_fp16_to_fixed_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_to_fixed_pipe.sv
// fp16_to_fixed_pipe: 3-stage fp16 -> signed Q(15-FRAC_BITS).FRAC_BITS converter, RNE rounding, saturation
module fp16_to_fixed_pipe #(
  parameter int FRAC_BITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf
);
  logic adv;
  logic v1_q, s1_q, spc1_q, nan1_q;
  logic [10:0] sig1_q;
  logic [4:0] e1_q;
  logic v2_q, s2_q, spc2_q, nan2_q;
  logic [32:0] mag2_q;
  logic v3_q, ovf3_q;
  logic [15:0] data3_q;
  logic signed [6:0] sh;
  logic [4:0] rsh;
  logic [34:0] ext;
  logic [32:0] mag_d, lim;
  logic ovf_d;
  logic [15:0] data_d;
  assign adv = !v3_q || out_ready;
  assign in_ready = adv;
  assign out_valid = v3_q;
  assign out_data = data3_q;
  assign out_ovf = ovf3_q;
  // Right shifts keep the dropped bits below ext[24] for guard/round/sticky.
  always_comb begin
    sh = 7'(e1_q) - 7'sd25 + 7'(FRAC_BITS);
    rsh = 5'(-sh);
    ext = {sig1_q, 24'b0} >> rsh;
    mag_d = sh[6] ? 33'(ext[34:24]) + 33'(ext[23] && (ext[22] || (|ext[21:0]) || ext[24]))
                  : 33'(sig1_q) << sh[4:0];
    lim = s2_q ? 33'd32768 : 33'd32767;
    ovf_d = v2_q && (spc2_q || mag2_q > lim);
    data_d = !v2_q ? 16'h0000
           : spc2_q ? ((nan2_q || !s2_q) ? 16'h7FFF : 16'h8000)
           : ovf_d ? (s2_q ? 16'h8000 : 16'h7FFF)
           : s2_q ? -mag2_q[15:0] : mag2_q[15:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {v1_q, s1_q, spc1_q, nan1_q, sig1_q, e1_q} <= '0;
      {v2_q, s2_q, spc2_q, nan2_q, mag2_q} <= '0;
      {v3_q, ovf3_q, data3_q} <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      s1_q <= in_data[15];
      e1_q <= (in_data[14:10] == 5'd0) ? 5'd1 : in_data[14:10];
      sig1_q <= {|in_data[14:10], in_data[9:0]};
      spc1_q <= &in_data[14:10];
      nan1_q <= (&in_data[14:10]) && (|in_data[9:0]);
      v2_q <= v1_q;
      s2_q <= s1_q;
      spc2_q <= spc1_q;
      nan2_q <= nan1_q;
      mag2_q <= mag_d;
      v3_q <= v2_q;
      ovf3_q <= ovf_d;
      data3_q <= data_d;
    end
  end
endmodule

// File: tb/tb_fp16_to_fixed_pipe.sv
// tb_fp16_to_fixed_pipe: randomized + directed checks against an arithmetic reference model
module tb_fp16_to_fixed_pipe;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, out_ovf;
  logic [15:0] in_data = 0, out_data;
  logic in_valid0 = 0, in_ready0, out_valid0, out_ready0 = 1, out_ovf0;
  logic [15:0] in_data0 = 0, out_data0;
  int errors = 0, checks = 0;
  logic [16:0] exp_q[$];
  int cyc_q[$];

  always #5 clk = ~clk;

  fp16_to_fixed_pipe #(.FRAC_BITS(12)) dut (.clk(clk), .reset(reset), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf));
  fp16_to_fixed_pipe #(.FRAC_BITS(0)) dut0 (.clk(clk), .reset(reset), .in_valid(in_valid0),
    .in_ready(in_ready0), .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_ovf(out_ovf0));

  // value = sig * 2^(E-25), scaled by 2^fb, rounded half-to-even by integer division
  function automatic logic [16:0] model(input logic [15:0] x, input int fb);
    int e = int'(x[14:10]);
    longint sig = (e != 0 ? 1024 : 0) + longint'(x[9:0]);
    int sh = (e == 0 ? 1 : e) - 25 + fb;
    longint q, den, r, lim;
    if (e == 31) return (x[9:0] != 0 || !x[15]) ? {1'b1, 16'h7FFF} : {1'b1, 16'h8000};
    if (sh >= 0) q = sig << sh;
    else begin
      den = 64'sd1 << (-sh);
      q = sig / den;
      r = sig % den;
      if (2 * r > den || (2 * r == den && q % 2 == 1)) q++;
    end
    lim = x[15] ? 32768 : 32767;
    if (q > lim) return {1'b1, x[15] ? 16'h8000 : 16'h7FFF};
    return {1'b0, 16'(x[15] ? -q : q)};
  endfunction

  function automatic logic [15:0] rand_fp();
    logic [15:0] d = 16'($urandom);
    if ($urandom_range(3) != 0) d[14:10] = 5'($urandom_range(0, 19));
    return d;
  endfunction

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 0 || out_data !== 0 || out_ovf !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h ovf=%b ready=%b, want 0 0000 0 1", out_valid, out_data, out_ovf, in_ready);
    end
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic test_directed();
    logic [15:0] vin[11] = '{16'h3C00, 16'hBC00, 16'h8000, 16'h0800, 16'h0E00, 16'h1001,
                             16'h0001, 16'h4800, 16'hC800, 16'h47FF, 16'h7C00};
    logic [16:0] vexp[11] = '{{1'b0,16'h1000}, {1'b0,16'hF000}, {1'b0,16'h0000}, {1'b0,16'h0000},
                              {1'b0,16'h0002}, {1'b0,16'h0002}, {1'b0,16'h0000}, {1'b1,16'h7FFF},
                              {1'b0,16'h8000}, {1'b0,16'h7FF0}, {1'b1,16'h7FFF}};
    for (int i = 0; i < 13; i++) begin
      logic [15:0] x;
      logic [16:0] want;
      x = i < 11 ? vin[i] : (i == 11 ? 16'hFC00 : 16'h7E01);
      want = i < 11 ? vexp[i] : (i == 11 ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF});
      @(posedge clk); #1 in_valid = 1; in_data = x; out_ready = 1;
      @(posedge clk); #1 in_valid = 0; in_data = 16'hFFFF;
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== (k == 3)) begin
          errors++;
          $display("FAIL latency %h c%0d: valid=%b want %b", x, k, out_valid, k == 3);
        end
        if (k < 3) @(posedge clk);
      end
      checks++;
      if ({out_ovf, out_data} !== want || want !== model(x, 12)) begin
        errors++;
        $display("FAIL directed %h: got %b/%h want %b/%h", x, out_ovf, out_data, want[16], want[15:0]);
      end
    end
  endtask

  // mode 0: 10 beats, out_ready low for cycles 4..9; mode 1: random valid/ready
  task automatic test_backpressure(input int mode, input int ncyc);
    int sent = 0, got = 0, nb;
    logic held = 0;
    logic [16:0] prev = 0;
    nb = mode == 0 ? 10 : 1000;
    exp_q.delete();
    for (int c = 0; c < ncyc + 60; c++) begin
      @(posedge clk); #1;
      in_valid = c < ncyc && sent < nb && (mode == 0 || $urandom_range(3) != 0);
      in_data = in_valid ? rand_fp() : 16'($urandom);
      out_ready = c >= ncyc || (mode == 0 ? !(c >= 4 && c <= 9) : $urandom_range(2) != 0);
      @(negedge clk);
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready c%0d: got %b ov=%b or=%b", c, in_ready, out_valid, out_ready);
      end
      if (held) begin
        checks++;
        if (!out_valid || {out_ovf, out_data} !== prev) begin
          errors++;
          $display("FAIL hold c%0d: got %b %b/%h want 1 %b/%h", c, out_valid, out_ovf, out_data, prev[16], prev[15:0]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra output c%0d: %b/%h", c, out_ovf, out_data);
        end else if ({out_ovf, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL stream c%0d: got %b/%h want %b/%h", c, out_ovf, out_data, exp_q[0][16], exp_q[0][15:0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, 12));
        sent++;
      end
      held = out_valid && !out_ready;
      prev = {out_ovf, out_data};
    end
    checks++;
    if (got != sent || exp_q.size() != 0 || (mode == 0 && sent != 10)) begin
      errors++;
      $display("FAIL count mode%0d: got %0d sent %0d pending %0d", mode, got, sent, exp_q.size());
    end
  endtask

  task automatic test_bubbles();
    exp_q.delete(); cyc_q.delete();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      in_valid = c < 30 && c % 2 == 0;
      in_data = rand_fp();
      out_ready = 1;
      @(negedge clk);
      checks++;
      if (out_valid !== (cyc_q.size() != 0 && cyc_q[0] + 3 == c)) begin
        errors++;
        $display("FAIL bubble timing c%0d: valid=%b", c, out_valid);
      end
      if (out_valid && exp_q.size() != 0) begin
        checks++;
        if ({out_ovf, out_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL bubble data c%0d: got %b/%h want %b/%h", c, out_ovf, out_data, exp_q[0][16], exp_q[0][15:0]);
        end
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, 12));
        cyc_q.push_back(c);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 in_valid = 1; in_data = 16'h3C00 + 16'(i);
    end
    @(posedge clk); #1 reset = 1; in_data = 16'h4000;
    @(negedge clk);
    @(posedge clk); #1 reset = 0; in_valid = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 0 || out_data !== 0 || out_ovf !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL mid reset: valid=%b data=%h ovf=%b ready=%b", out_valid, out_data, out_ovf, in_ready);
    end
    @(posedge clk); #1 in_valid = 1; in_data = 16'hBE00;
    @(posedge clk); #1 in_valid = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (k == 3) || (k == 3 && {out_ovf, out_data} !== {1'b0, 16'hE800})) begin
        errors++;
        $display("FAIL post-reset c%0d: valid=%b %b/%h want %b 0/e800", k, out_valid, out_ovf, out_data, k == 3);
      end
      if (k < 3) @(posedge clk);
    end
  endtask

  task automatic test_frac0();
    logic [15:0] vin[5] = '{16'h3C00, 16'h3800, 16'h3E00, 16'h7BFF, 16'hC0E0};
    logic [16:0] vexp[5] = '{{1'b0,16'h0001}, {1'b0,16'h0000}, {1'b0,16'h0002}, {1'b1,16'h7FFF}, {1'b0,16'hFFFE}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 in_valid0 = 1; in_data0 = vin[i];
      @(posedge clk); #1 in_valid0 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid0 !== 1 || {out_ovf0, out_data0} !== vexp[i] || vexp[i] !== model(vin[i], 0)) begin
        errors++;
        $display("FAIL frac0 %h: got %b %b/%h want 1 %b/%h", vin[i], out_valid0, out_ovf0, out_data0, vexp[i][16], vexp[i][15:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure(0, 20);
    test_bubbles();
    test_backpressure(1, 600);
    test_reset_mid();
    test_frac0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
